// File: rtl/cnt_timer_arbiter.sv
// Round-robin owner of a shared down-counting timer: loads the winner's reload
// value, counts its requested number of zero edges, then pulses done and rotates.
module cnt_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int PW    = 4
) (
    input  logic                  i_clk,
    input  logic                  inner_rst_n,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_req_value,
    input  logic [NREQ*PW-1:0]    i_req_periods,
    output logic [NREQ-1:0]       o_grant,
    output logic [NREQ-1:0]       o_done,
    output logic                  o_cnt_load,
    output logic [WIDTH-1:0]      o_cnt_value,
    input  logic                  i_cnt_zero,
    output logic                  o_busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   owner_reg;
    logic [PW-1:0]   periods_reg;
    logic [PW-1:0]   exp_cnt_reg;
    logic            zero_hist_reg;

    logic [WIDTH-1:0] value_arr   [NREQ];
    logic [PW-1:0]    periods_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign value_arr[gi]   = i_req_value[gi*WIDTH +: WIDTH];
            assign periods_arr[gi] = i_req_periods[gi*PW +: PW];
        end
    endgenerate

    // Walk from the highest offset down so the nearest requester at or after ptr wins.
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic [IW-1:0] cand_idx;
    int            cand;

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = int'(ptr_reg) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (i_req[cand_idx]) begin
                win_idx   = cand_idx;
                win_found = 1'b1;
            end
        end
    end

    logic [NREQ-1:0] win_onehot;
    logic [IW-1:0]   ptr_after_owner;
    logic            owner_req;
    logic            zero_rise;
    logic [PW-1:0]   exp_cnt_next;
    logic [PW-1:0]   win_periods;

    assign win_onehot      = NREQ'(1) << win_idx;
    assign ptr_after_owner = (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
    assign owner_req       = i_req[owner_reg];
    assign zero_rise       = i_cnt_zero & ~zero_hist_reg;
    assign exp_cnt_next    = (&exp_cnt_reg) ? exp_cnt_reg : exp_cnt_reg + 1'b1;
    assign win_periods     = (periods_arr[win_idx] == '0) ? PW'(1) : periods_arr[win_idx];

    always_ff @(posedge i_clk or negedge inner_rst_n) begin
        if (!inner_rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            periods_reg   <= '0;
            exp_cnt_reg   <= '0;
            zero_hist_reg <= 1'b1;
            o_grant       <= '0;
            o_done        <= '0;
            o_cnt_load    <= 1'b0;
            o_cnt_value   <= '0;
            o_busy        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    o_done     <= '0;
                    o_cnt_load <= 1'b0;
                    if (win_found) begin
                        owner_reg   <= win_idx;
                        o_grant     <= win_onehot;
                        o_cnt_value <= value_arr[win_idx];
                        periods_reg <= win_periods;
                        o_cnt_load  <= 1'b1;
                        o_busy      <= 1'b1;
                        state_reg   <= LOAD;
                    end
                end
                LOAD: begin
                    o_cnt_load    <= 1'b0;
                    exp_cnt_reg   <= '0;
                    // A zero level already present at load time must not count.
                    zero_hist_reg <= 1'b1;
                    if (!owner_req) begin
                        o_grant   <= '0;
                        o_busy    <= 1'b0;
                        ptr_reg   <= ptr_after_owner;
                        state_reg <= IDLE;
                    end else begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    zero_hist_reg <= i_cnt_zero;
                    if (!owner_req) begin
                        // Abandonment wins over a coincident final expiry.
                        o_grant   <= '0;
                        o_busy    <= 1'b0;
                        ptr_reg   <= ptr_after_owner;
                        state_reg <= IDLE;
                    end else if (zero_rise) begin
                        exp_cnt_reg <= exp_cnt_next;
                        if (exp_cnt_next == periods_reg) begin
                            o_done    <= o_grant;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    o_done    <= '0;
                    o_grant   <= '0;
                    o_busy    <= 1'b0;
                    ptr_reg   <= ptr_after_owner;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_timer_arbiter.sv
// Bench for cnt_timer_arbiter: table of single grants plus hand-written
// rotation, abort, collision, held-zero and mid-run reset sequences.
module tb_cnt_timer_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int PW    = 4;

    logic                  clk;
    logic                  inner_rst_n;
    logic [NREQ-1:0]       i_req;
    logic [NREQ*WIDTH-1:0] i_req_value;
    logic [NREQ*PW-1:0]    i_req_periods;
    logic [NREQ-1:0]       o_grant;
    logic [NREQ-1:0]       o_done;
    logic                  o_cnt_load;
    logic [WIDTH-1:0]      o_cnt_value;
    logic                  i_cnt_zero;
    logic                  o_busy;

    logic use_man;
    logic man_zero;
    logic tmr_zero;
    assign i_cnt_zero = use_man ? man_zero : tmr_zero;

    cnt_timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .PW(PW)) dut (
        .i_clk        (clk),
        .inner_rst_n  (inner_rst_n),
        .i_req        (i_req),
        .i_req_value  (i_req_value),
        .i_req_periods(i_req_periods),
        .o_grant      (o_grant),
        .o_done       (o_done),
        .o_cnt_load   (o_cnt_load),
        .o_cnt_value  (o_cnt_value),
        .i_cnt_zero   (i_cnt_zero),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  grant;
        logic [15:0] value;
    } load_t;

    typedef struct {
        logic [3:0] grant;
        int         edges;
    } done_t;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] base;
        logic [3:0]  per;
        logic [3:0]  exp_grant;
        logic [15:0] exp_value;
        int          exp_edges;
    } vec_t;

    load_t load_q[$];
    done_t done_q[$];
    vec_t  vecs[7];

    int total = 0;
    int bad   = 0;
    int edges = 0;
    logic zprev = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic set_inputs(input logic [3:0] req, input logic [15:0] base, input logic [3:0] per);
        for (int k = 0; k < NREQ; k++) begin
            i_req_value[k*WIDTH +: WIDTH] = base + 16'(k);
        end
        i_req_periods = {NREQ{per}};
        i_req = req;
    endtask

    task automatic wait_load(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (o_cnt_load) return;
        end
        fail_now("wait_load");
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (|o_done) return;
        end
        fail_now("wait_done");
    endtask

    task automatic drop_and_settle();
        @(posedge clk);
        #1 i_req = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Free-running timer model: one-cycle zero pulse every 6 cycles.
    initial begin
        int tphase;
        tphase = 0;
        tmr_zero = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tphase = (tphase == 5) ? 0 : tphase + 1;
            tmr_zero = (tphase == 0);
        end
    end

    // Scoreboard monitor; also tracks zero edges the DUT should have counted.
    initial begin
        load_t lr;
        done_t dr;
        forever begin
            @(negedge clk);
            if (inner_rst_n) begin
                if (o_cnt_load) begin
                    $display("load grant=%b value=%h", o_grant, o_cnt_value);
                    if (load_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL load_unexp: grant=%b value=%h, none expected", o_grant, o_cnt_value);
                    end else begin
                        lr = load_q.pop_front();
                        chk("load_grant", 32'(o_grant), 32'(lr.grant));
                        chk("load_value", 32'(o_cnt_value), 32'(lr.value));
                    end
                end
                if (|o_done) begin
                    $display("done mask=%b after %0d zero edges", o_done, edges);
                    if (done_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done_unexp: done=%b, none expected", o_done);
                    end else begin
                        dr = done_q.pop_front();
                        chk("done_mask", 32'(o_done), 32'(dr.grant));
                        chk("done_edges", 32'(edges), 32'(dr.edges));
                    end
                end
                if (o_cnt_load) begin
                    edges = 0;
                    zprev = 1'b1;
                end else begin
                    if (i_cnt_zero && !zprev && o_busy) edges++;
                    zprev = i_cnt_zero;
                end
            end
        end
    end

    initial begin
        int ndone;
        logic [3:0] base_grant;

        vecs[0] = '{4'b0011, 16'h0100, 4'd2,  4'b0010, 16'h0101, 2};
        vecs[1] = '{4'b0011, 16'h0200, 4'd1,  4'b0001, 16'h0200, 1};
        vecs[2] = '{4'b1001, 16'hA000, 4'd0,  4'b1000, 16'hA003, 1};
        vecs[3] = '{4'b1111, 16'hFFF0, 4'd3,  4'b0001, 16'hFFF0, 3};
        vecs[4] = '{4'b0100, 16'h1234, 4'd15, 4'b0100, 16'h1236, 15};
        vecs[5] = '{4'b0110, 16'h0000, 4'd1,  4'b0010, 16'h0001, 1};
        vecs[6] = '{4'b0010, 16'h0004, 4'd3,  4'b0010, 16'h0005, 3};

        inner_rst_n   = 1'b0;
        use_man       = 1'b0;
        man_zero      = 1'b0;
        i_req         = '0;
        i_req_value   = '0;
        i_req_periods = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_load", 32'(o_cnt_load), 32'h0);
        chk("rst_value", 32'(o_cnt_value), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        @(posedge clk);
        #1 inner_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Rotation with all requests held, one expiry each
        for (int k = 0; k < 5; k++) begin
            base_grant = 4'b0001 << (k % NREQ);
            load_q.push_back('{base_grant, 16'h0010 + 16'(k % NREQ)});
            done_q.push_back('{base_grant, 1});
        end
        set_inputs(4'b1111, 16'h0010, 4'd1);
        ndone = 0;
        for (int i = 0; i < 400 && ndone < 5; i++) begin
            @(negedge clk);
            if (|o_done) ndone++;
        end
        if (ndone < 5) fail_now("rotation");
        drop_and_settle();

        // Table of single grants, each with latency check
        foreach (vecs[v]) begin
            load_q.push_back('{vecs[v].exp_grant, vecs[v].exp_value});
            done_q.push_back('{vecs[v].exp_grant, vecs[v].exp_edges});
            set_inputs(vecs[v].req, vecs[v].base, vecs[v].per);
            @(negedge clk);
            chk("vec_pre_grant", 32'(o_grant), 32'h0);
            @(negedge clk);
            chk("vec_grant", 32'(o_grant), 32'(vecs[v].exp_grant));
            chk("vec_load", 32'(o_cnt_load), 32'h1);
            wait_done(200);
            drop_and_settle();
        end

        // Periods 0 with zero held high from before the load: needs a fresh rise
        use_man  = 1'b1;
        man_zero = 1'b1;
        load_q.push_back('{4'b0001, 16'h0000});
        set_inputs(4'b0001, 16'h0000, 4'd0);
        wait_load(10);
        repeat (20) @(negedge clk);
        chk("held_zero_busy", 32'(o_busy), 32'h1);
        chk("held_zero_grant", 32'(o_grant), 32'h1);
        @(posedge clk);
        #1 man_zero = 1'b0;
        done_q.push_back('{4'b0001, 1});
        @(posedge clk);
        #1 man_zero = 1'b1;
        wait_done(10);
        drop_and_settle();
        use_man = 1'b0;

        // Abort: requester 2 drops after one of four expiries, requester 3 follows
        load_q.push_back('{4'b0100, 16'h0702});
        load_q.push_back('{4'b1000, 16'h0703});
        done_q.push_back('{4'b1000, 4});
        set_inputs(4'b1100, 16'h0700, 4'd4);
        wait_load(10);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (edges >= 1) break;
        end
        if (edges < 1) fail_now("abort_edge");
        #1 i_req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk("abort_grant_clr", 32'(o_grant), 32'h0);
        chk("abort_no_done", 32'(o_done), 32'h0);
        @(negedge clk);
        chk("abort_next_grant", 32'(o_grant), 32'b1000);
        wait_done(100);
        drop_and_settle();

        // Final expiry and abandonment on the same edge
        use_man  = 1'b1;
        man_zero = 1'b0;
        load_q.push_back('{4'b0010, 16'h0501});
        set_inputs(4'b0010, 16'h0500, 4'd2);
        wait_load(10);
        @(posedge clk);
        #1 man_zero = 1'b1;
        @(posedge clk);
        #1 man_zero = 1'b0;
        @(posedge clk);
        #1 man_zero = 1'b1;
        i_req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("collide_grant", 32'(o_grant), 32'h0);
        chk("collide_busy", 32'(o_busy), 32'h0);
        chk("collide_done", 32'(o_done), 32'h0);
        repeat (2) @(posedge clk);
        #1 use_man = 1'b0;

        // Reset mid-run clears outputs at once and returns ptr to 0
        load_q.push_back('{4'b0100, 16'h0302});
        set_inputs(4'b0101, 16'h0300, 4'd3);
        wait_load(10);
        repeat (3) @(negedge clk);
        #2 inner_rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(o_grant), 32'h0);
        chk("mid_rst_load", 32'(o_cnt_load), 32'h0);
        chk("mid_rst_done", 32'(o_done), 32'h0);
        chk("mid_rst_busy", 32'(o_busy), 32'h0);
        load_q.push_back('{4'b0001, 16'h0300});
        done_q.push_back('{4'b0001, 3});
        @(posedge clk);
        #1 inner_rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(o_grant), 32'h0);
        @(negedge clk);
        chk("post_rst_grant", 32'(o_grant), 32'b0001);
        wait_done(100);
        drop_and_settle();

        repeat (3) @(posedge clk);
        chk("load_q_empty", 32'(load_q.size()), 32'h0);
        chk("done_q_empty", 32'(done_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnt_timer_arbiter.md
Name: cnt_timer_arbiter

Overview:
- Round-robin scheduler that shares one down-counting compare timer among NREQ requesters.
- On each grant it loads the winner's reload value into the timer, then counts the requested number of timer expiries (zero events).
- When the count completes it pulses done to that requester and rotates priority to the next requester.
- Sits between requesting blocks and the shared timer's load/value/zero interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, timer reload value width.
- PW, 4, width of the per-requester expiry-count field.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- inner_rst_n  in  1  reset inner_rst_n, asynchronous, active-low.
- i_req  in  NREQ  per-requester request level; held until done or abandoned.
- i_req_value  in  NREQ*WIDTH  packed reload values; requester k uses bits [k*WIDTH +: WIDTH].
- i_req_periods  in  NREQ*PW  packed expiry counts; requester k uses bits [k*PW +: PW].
- o_grant  out  NREQ  one-hot current owner; all zero when idle.
- o_done  out  NREQ  one-cycle pulse to the owner on completion.
- o_cnt_load  out  1  one-cycle load strobe to the shared timer.
- o_cnt_value  out  WIDTH  reload value presented with o_cnt_load; holds the latched value otherwise.
- i_cnt_zero  in  1  timer at-zero flag; level, may stay high for one or more cycles.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, inner_rst_n low): state=IDLE, o_grant=0, o_done=0, o_cnt_load=0, o_cnt_value=0, o_busy=0, rr pointer=0, expiry counter=0, zero-edge history=1.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any i_req bit is high, select the first set bit searching from (ptr) upward with wrap.
  - Latch the winner's value into o_cnt_value.
  - Latch its periods; a periods value of 0 is treated as 1.
  - Set o_grant one-hot and go to LOAD at the next edge.
  - Grant latency: 1 cycle from i_req sampled high in IDLE.
- LOAD:
  - o_cnt_load=1 for exactly this cycle.
  - Clear the expiry counter; set the zero-edge history to 1 so a stale zero level is not counted.
  - Go to RUN.
- RUN:
  - Count one expiry per rising edge of i_cnt_zero (i_cnt_zero=1 with previous sample 0).
  - The expiry counter is PW bits, saturating, and compared against latched periods.
  - When the count reaches latched periods, go to DONE on the same edge that records the final expiry.
- DONE:
  - o_done[owner]=1 for one cycle; o_grant is cleared at the end of this cycle.
  - ptr=owner+1 mod NREQ; go to IDLE.
- Abort: if i_req[owner] drops in LOAD or RUN, go to IDLE at the next edge.
  - o_grant is cleared, no o_done pulse is issued, and ptr still advances past the owner.
  - The timer is left free-running; no reload is issued.
- Fairness:
  - A requester still requesting after its done re-competes with lowest priority.
  - With all NREQ bits held high, grants rotate 0,1,..,NREQ-1,0.
- Request changes: i_req changes for non-owners during LOAD/RUN/DONE are ignored until IDLE.
- Value/period changes: i_req_value and i_req_periods are sampled only in IDLE; later changes have no effect on the current grant.
- Simultaneous events:
  - A zero edge in the LOAD cycle is ignored (history forced).
  - In RUN, an abort and the final expiry on the same cycle resolve as abort.
- Gap between grants: at least 1 IDLE cycle.
- o_busy=1 in LOAD, RUN and DONE.

Test Plan:
- Reset during RUN (inner_rst_n low mid-cycle) -> o_grant, o_cnt_load and o_done go to 0 immediately; after release, ptr=0 and state=IDLE.
- Single request: i_req=0010, value=0x0005, periods=3; timer model pulses i_cnt_zero every 6 cycles.
  - Required response: o_grant=0010 one cycle after the request.
  - o_cnt_load=1 with o_cnt_value=0x0005 for one cycle.
  - o_done[1] pulses after the 3rd zero edge.
- Rotation: i_req=1111 held, periods=1 each -> grant order 0001, 0010, 0100, 1000, 0001; each followed by a single done pulse.
- Periods=0 with value=0 -> behaves as periods=1; a zero level held high continuously from load yields no done until a new rising edge occurs.
- Abort: requester 2 drops i_req after 1 of 4 expiries -> grant clears next cycle, no o_done; next grant goes to requester 3 if it is requesting.
- Final-expiry/abort collision: i_req[owner] drops on the cycle of the final zero edge -> no done pulse; state returns to IDLE.
